// File: rtl/hash_if_pkg.sv
// Shared definitions for the hash host bridge: FSM state codes and sizing helpers.
package hash_if_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_LEN   = 3'd0;
    localparam state_t S_MSG   = 3'd1;
    localparam state_t S_START = 3'd2;
    localparam state_t S_BUSY  = 3'd3;
    localparam state_t S_RD    = 3'd4;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rd_words(input int data_w, input int digest_w);
        return digest_w / data_w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hash_digest_ser.sv
// Digest serialiser: returns one DATA_W slice per read-advance strobe, most significant slice first.
module hash_digest_ser
    import hash_if_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DIGEST_W = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  logic [DIGEST_W-1:0] digest,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                last
);

    localparam int RD_WORDS = rd_words(DATA_W, DIGEST_W);
    localparam int RW       = cnt_w(RD_WORDS);

    logic [RW-1:0]     rcnt_r;
    logic [DATA_W-1:0] word_s;

    assign last = (rcnt_r == RW'(RD_WORDS - 1));

    // Select the slice addressed by the read pointer; slice 0 sits at the digest MSBs
    always_comb begin
        word_s = '0;
        for (int k = 0; k < RD_WORDS; k++) begin
            word_s = (rcnt_r == RW'(k)) ? digest[DIGEST_W-1-k*DATA_W -: DATA_W] : word_s;
        end
    end

    // Capture one slice per accepted read and step the pointer, wrapping after the last slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_r <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (adv) begin
            rdata  <= word_s;
            rvalid <= 1'b1;
            rcnt_r <= last ? '0 : rcnt_r + RW'(1);
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/hash_host_if.sv
// Host-side bridge to a block hash core: header and block loading, core start/busy handshake, digest readout.
// Optional block counter enabled by defining HCIF_BLK_CNT_EN.
module hash_host_if
    import hash_if_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DIGEST_W    = 256,
    parameter int LEN_WORDS   = 4,
    parameter int BLOCK_WORDS = 96
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wdata,
    output logic                wr_ready,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                err,
    output logic [DATA_W-1:0]   core_data,
    output logic                ld_cnt,
    output logic                ld_msg,
    output logic                start,
    input  logic                busy,
    input  logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic [31:0]         blk_cnt
);

    localparam int WW = cnt_w(max2(LEN_WORDS, BLOCK_WORDS));

    state_t        state_r;
    logic [WW-1:0] wcnt_r;
    logic          dv_r;
    logic          err_r;
    logic          busy_chk_r;

    logic in_len_s, in_msg_s, wcnt_zero_s, len_last_s, blk_last_s;
    logic rd_adv_s, wr_acc_s, blk_done_s, last_rd_s;

    // Request decode; a legal read takes priority over a simultaneous write
    always_comb begin
        in_len_s    = (state_r == S_LEN);
        in_msg_s    = (state_r == S_MSG);
        wcnt_zero_s = (wcnt_r == '0);
        len_last_s  = (wcnt_r == WW'(LEN_WORDS - 1));
        blk_last_s  = (wcnt_r == WW'(BLOCK_WORDS - 1));
        rd_adv_s    = rd_en && ((in_msg_s && dv_r && wcnt_zero_s) || (state_r == S_RD));
        wr_ready    = (in_len_s || in_msg_s) && !rd_adv_s;
        wr_acc_s    = wr_en && wr_ready;
        ld_cnt      = wr_acc_s && in_len_s;
        ld_msg      = wr_acc_s && in_msg_s;
        start       = (state_r == S_START) && !busy;
        blk_done_s  = (state_r == S_BUSY) && busy_chk_r && !busy;
    end

    assign core_data    = wdata;
    assign digest_valid = dv_r;
    assign err          = err_r;

    // Main control FSM; busy is ignored on the first S_BUSY cycle while the core reacts to start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_LEN;
            wcnt_r     <= '0;
            dv_r       <= 1'b0;
            err_r      <= 1'b0;
            busy_chk_r <= 1'b0;
        end else begin
            err_r <= (rd_en && !rd_adv_s) || (wr_en && !wr_ready);
            case (state_r)
                S_LEN: begin
                    if (wr_acc_s) begin
                        if (len_last_s) begin
                            state_r <= S_MSG;
                            wcnt_r  <= '0;
                        end else begin
                            wcnt_r <= wcnt_r + WW'(1);
                        end
                    end
                end
                S_MSG: begin
                    if (rd_adv_s) begin
                        state_r <= S_RD;
                    end else if (wr_acc_s) begin
                        if (wcnt_zero_s) begin
                            dv_r <= 1'b0;
                        end
                        if (blk_last_s) begin
                            state_r <= S_START;
                            wcnt_r  <= '0;
                        end else begin
                            wcnt_r <= wcnt_r + WW'(1);
                        end
                    end
                end
                S_START: begin
                    if (!busy) begin
                        state_r    <= S_BUSY;
                        busy_chk_r <= 1'b0;
                    end
                end
                S_BUSY: begin
                    busy_chk_r <= 1'b1;
                    if (blk_done_s) begin
                        state_r <= S_MSG;
                        dv_r    <= 1'b1;
                    end
                end
                S_RD: begin
                    if (rd_adv_s && last_rd_s) begin
                        state_r <= S_LEN;
                        dv_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_LEN;
                    wcnt_r  <= '0;
                    dv_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef HCIF_BLK_CNT_EN
    logic [31:0] blk_cnt_r;

    // Completed-block counter, wraps modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_r <= 32'd0;
        end else if (blk_done_s) begin
            blk_cnt_r <= blk_cnt_r + 32'd1;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    assign blk_cnt = blk_cnt_r;
`else
    assign blk_cnt = 32'd0;
`endif

    hash_digest_ser #(
        .DATA_W   (DATA_W),
        .DIGEST_W (DIGEST_W)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .adv    (rd_adv_s),
        .digest (digest),
        .rdata  (rdata),
        .rvalid (rvalid),
        .last   (last_rd_s)
    );

endmodule

// File: tb/tb_hash_host_if.sv
// Self-checking bench for hash_host_if: default configuration plus a 32/512/2/16 instance.
module tb_hash_host_if;

    localparam int DW = 16, GW = 256, LW = 4, BW = 96, NR = GW / DW;
    localparam int DW2 = 32, GW2 = 512, LW2 = 2, BW2 = 16, NR2 = GW2 / DW2;
`ifdef HCIF_BLK_CNT_EN
    localparam bit BLK_EN = 1'b1;
`else
    localparam bit BLK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en = 1'b0, rd_en = 1'b0, busy = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [GW-1:0] digest = '0;
    logic          wr_ready, rvalid, err, ld_cnt, ld_msg, start, digest_valid;
    logic [DW-1:0] rdata, core_data;
    logic [31:0]   blk_cnt;

    logic           wr_en2 = 1'b0, rd_en2 = 1'b0, busy2 = 1'b0;
    logic [DW2-1:0] wdata2 = '0;
    logic [GW2-1:0] digest2 = '0;
    logic           wr_ready2, rvalid2, err2, ld_cnt2, ld_msg2, start2, digest_valid2;
    logic [DW2-1:0] rdata2, core_data2;
    logic [31:0]    blk_cnt2;

    hash_host_if dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .wr_ready(wr_ready),
        .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .err(err), .core_data(core_data),
        .ld_cnt(ld_cnt), .ld_msg(ld_msg), .start(start), .busy(busy), .digest(digest),
        .digest_valid(digest_valid), .blk_cnt(blk_cnt)
    );

    hash_host_if #(.DATA_W(DW2), .DIGEST_W(GW2), .LEN_WORDS(LW2), .BLOCK_WORDS(BW2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .wdata(wdata2), .wr_ready(wr_ready2),
        .rd_en(rd_en2), .rdata(rdata2), .rvalid(rvalid2), .err(err2), .core_data(core_data2),
        .ld_cnt(ld_cnt2), .ld_msg(ld_msg2), .start(start2), .busy(busy2), .digest(digest2),
        .digest_valid(digest_valid2), .blk_cnt(blk_cnt2)
    );

    int n_tests = 0, n_fail = 0;
    int exp_blk = 0;

    // observations from the last step
    logic          o_ldc, o_ldm, o_start, o_wrdy, o_err, o_rv, o_dv;
    logic [DW-1:0] o_cd, o_rd;
    logic           p_ldc, p_ldm, p_start, p_wrdy, p_err, p_rv, p_dv;
    logic [DW2-1:0] p_cd, p_rd;

    // block-run tallies
    int c_ldc, c_ldm, c_start, c_cd_bad;
    bit start_ok, dv_busy, dv_after, dv_first;

    logic [DW-1:0]  words  [NR];
    logic [DW2-1:0] words2 [NR2];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        @(negedge clk);
        wr_en = we; wdata = wd; rd_en = re;
        #1;
        o_ldc = ld_cnt; o_ldm = ld_msg; o_start = start; o_wrdy = wr_ready; o_cd = core_data;
        @(posedge clk);
        #1;
        o_err = err; o_rv = rvalid; o_rd = rdata; o_dv = digest_valid;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic step2(input logic we, input logic [DW2-1:0] wd, input logic re);
        @(negedge clk);
        wr_en2 = we; wdata2 = wd; rd_en2 = re;
        #1;
        p_ldc = ld_cnt2; p_ldm = ld_msg2; p_start = start2; p_wrdy = wr_ready2; p_cd = core_data2;
        @(posedge clk);
        #1;
        p_err = err2; p_rv = rvalid2; p_rd = rdata2; p_dv = digest_valid2;
        wr_en2 = 1'b0; rd_en2 = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; busy = 1'b0;
        wr_en2 = 1'b0; rd_en2 = 1'b0; busy2 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_blk = 0;
    endtask

    task automatic set_digest(input bit fixed);
        for (int k = 0; k < NR; k++) words[k] = fixed ? DW'(k + 1) : DW'($urandom);
        digest = '0;
        for (int k = 0; k < NR; k++) digest = {digest[GW-DW-1:0], words[k]};
    endtask

    // Stimulus only: optional header, one full block, core busy for busy_cycles, first busy-low cycle
    task automatic run_block(input bit with_len, input int busy_cycles);
        logic [DW-1:0] d;
        c_ldc = 0; c_ldm = 0; c_start = 0; c_cd_bad = 0;
        dv_busy = 1'b0; dv_first = 1'b1;
        if (with_len) begin
            for (int i = 0; i < LW; i++) begin
                d = DW'($urandom); step(1'b1, d, 1'b0);
                c_ldc += int'(o_ldc); c_ldm += int'(o_ldm); c_start += int'(o_start);
                if (o_cd !== d) c_cd_bad++;
            end
        end
        for (int i = 0; i < BW; i++) begin
            d = DW'($urandom); step(1'b1, d, 1'b0);
            c_ldc += int'(o_ldc); c_ldm += int'(o_ldm); c_start += int'(o_start);
            if (o_cd !== d) c_cd_bad++;
            if (i == 0) dv_first = o_dv;
        end
        step(1'b0, '0, 1'b0);
        start_ok = o_start;
        busy = 1'b1;
        repeat (busy_cycles) begin
            step(1'b0, '0, 1'b0);
            c_start += int'(o_start);
            if (o_dv) dv_busy = 1'b1;
        end
        busy = 1'b0;
        step(1'b0, '0, 1'b0);
        dv_after = o_dv;
        exp_blk++;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (rdata !== '0 || rvalid !== 1'b0 || err !== 1'b0 || start !== 1'b0 || digest_valid !== 1'b0 ||
            blk_cnt !== 32'd0 || ld_cnt !== 1'b0 || ld_msg !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got rdata=%h rvalid=%b err=%b start=%b dv=%b blk=%0d ldc=%b ldm=%b wrdy=%b exp zeros with wrdy=1",
                     rdata, rvalid, err, start, digest_valid, blk_cnt, ld_cnt, ld_msg, wr_ready);
        end
    endtask

    task automatic test_block();
        do_reset();
        run_block(1'b1, 10);
        n_tests++; if (c_ldc !== LW) begin n_fail++; $display("FAIL blk_ld_cnt got %0d exp %0d", c_ldc, LW); end
        n_tests++; if (c_ldm !== BW) begin n_fail++; $display("FAIL blk_ld_msg got %0d exp %0d", c_ldm, BW); end
        n_tests++; if (c_cd_bad !== 0) begin n_fail++; $display("FAIL blk_core_data got %0d bad words exp 0", c_cd_bad); end
        n_tests++; if (start_ok !== 1'b1 || c_start !== 0) begin n_fail++; $display("FAIL blk_start got on_time=%b extra=%0d exp 1 and 0", start_ok, c_start); end
        n_tests++; if (dv_busy !== 1'b0 || dv_after !== 1'b1) begin n_fail++; $display("FAIL blk_dv got during_busy=%b after=%b exp 0 and 1", dv_busy, dv_after); end
        n_tests++; if (blk_cnt !== (BLK_EN ? 32'(exp_blk) : 32'd0)) begin n_fail++; $display("FAIL blk_cnt1 got %0d exp %0d", blk_cnt, BLK_EN ? exp_blk : 0); end
    endtask

    task automatic test_read(input bit fixed);
        do_reset();
        set_digest(fixed);
        run_block(1'b1, int'($urandom_range(2, 12)));
        for (int k = 0; k < NR; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, '0, 1'b0);
                n_tests++; if (o_rv !== 1'b0) begin n_fail++; $display("FAIL read_gap %0d got rvalid=%b exp 0", k, o_rv); end
            end
            step(1'b0, '0, 1'b1);
            n_tests++;
            if (o_rv !== 1'b1 || o_rd !== words[k] || o_err !== 1'b0) begin
                n_fail++;
                $display("FAIL read_word %0d got rvalid=%b rdata=%h err=%b exp 1 %h 0", k, o_rv, o_rd, o_err, words[k]);
            end
        end
        n_tests++; if (o_dv !== 1'b0) begin n_fail++; $display("FAIL read_dv_clear got %b exp 0", o_dv); end
        step(1'b1, DW'($urandom), 1'b0);
        n_tests++; if (o_ldc !== 1'b1 || o_ldm !== 1'b0) begin n_fail++; $display("FAIL read_back_to_len got ldc=%b ldm=%b exp 1 0", o_ldc, o_ldm); end
    endtask

    task automatic test_two_block();
        do_reset();
        run_block(1'b1, 5);
        run_block(1'b0, 7);
        n_tests++; if (c_ldc !== 0 || c_ldm !== BW) begin n_fail++; $display("FAIL two_blk_loads got ldc=%0d ldm=%0d exp 0 %0d", c_ldc, c_ldm, BW); end
        n_tests++; if (dv_first !== 1'b0) begin n_fail++; $display("FAIL two_blk_dv_clear got %b exp 0", dv_first); end
        n_tests++; if (start_ok !== 1'b1 || dv_after !== 1'b1) begin n_fail++; $display("FAIL two_blk_start got start=%b dv=%b exp 1 1", start_ok, dv_after); end
        n_tests++; if (blk_cnt !== (BLK_EN ? 32'(exp_blk) : 32'd0)) begin n_fail++; $display("FAIL blk_cnt2 got %0d exp %0d", blk_cnt, BLK_EN ? exp_blk : 0); end
    endtask

    task automatic test_illegal();
        int nm;
        do_reset();
        set_digest(1'b0);
        nm = 0;
        for (int i = 0; i < LW; i++) step(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) begin step(1'b1, DW'($urandom), 1'b0); nm += int'(o_ldm); end
        step(1'b0, '0, 1'b1);
        n_tests++; if (o_err !== 1'b1 || o_rv !== 1'b0 || o_ldm !== 1'b0) begin n_fail++; $display("FAIL ill_rd_midblk got err=%b rv=%b ldm=%b exp 1 0 0", o_err, o_rv, o_ldm); end
        c_start = 0;
        for (int i = 5; i < BW; i++) begin step(1'b1, DW'($urandom), 1'b0); nm += int'(o_ldm); c_start += int'(o_start); end
        n_tests++; if (nm !== BW || c_start !== 0) begin n_fail++; $display("FAIL ill_blk_count got ldm=%0d starts=%0d exp %0d 0", nm, c_start, BW); end
        busy = 1'b1;
        step(1'b1, DW'($urandom), 1'b0);
        n_tests++; if (o_err !== 1'b1 || o_wrdy !== 1'b0 || o_ldm !== 1'b0 || o_ldc !== 1'b0 || o_start !== 1'b0) begin
            n_fail++; $display("FAIL ill_wr_start got err=%b wrdy=%b ldm=%b ldc=%b start=%b exp 1 0 0 0 0", o_err, o_wrdy, o_ldm, o_ldc, o_start); end
        busy = 1'b0;
        step(1'b0, '0, 1'b0);
        n_tests++; if (o_start !== 1'b1) begin n_fail++; $display("FAIL ill_start_held got %b exp 1", o_start); end
        busy = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        n_tests++; if (o_err !== 1'b1 || o_rv !== 1'b0) begin n_fail++; $display("FAIL ill_rd_busy got err=%b rv=%b exp 1 0", o_err, o_rv); end
        busy = 1'b0;
        step(1'b0, '0, 1'b0);
        exp_blk++;
        n_tests++; if (o_dv !== 1'b1) begin n_fail++; $display("FAIL ill_dv_after got %b exp 1", o_dv); end
        step(1'b1, DW'($urandom), 1'b1);
        n_tests++; if (o_wrdy !== 1'b0 || o_ldm !== 1'b0 || o_rv !== 1'b1 || o_rd !== words[0] || o_err !== 1'b1) begin
            n_fail++; $display("FAIL ill_rd_wins got wrdy=%b ldm=%b rv=%b rdata=%h err=%b exp 0 0 1 %h 1", o_wrdy, o_ldm, o_rv, o_rd, o_err, words[0]); end
        for (int k = 1; k < NR; k++) step(1'b0, '0, 1'b1);
        n_tests++; if (o_rd !== words[NR-1] || o_dv !== 1'b0) begin n_fail++; $display("FAIL ill_read_out got rdata=%h dv=%b exp %h 0", o_rd, o_dv, words[NR-1]); end
        step(1'b0, '0, 1'b1);
        n_tests++; if (o_err !== 1'b1 || o_rv !== 1'b0) begin n_fail++; $display("FAIL ill_rd_len got err=%b rv=%b exp 1 0", o_err, o_rv); end
        step(1'b1, DW'($urandom), 1'b0);
        n_tests++; if (o_ldc !== 1'b1 || o_err !== 1'b0) begin n_fail++; $display("FAIL ill_len_after got ldc=%b err=%b exp 1 0", o_ldc, o_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_block(1'b1, 3);
        for (int i = 0; i < 40; i++) step(1'b1, DW'($urandom), 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (start !== 1'b0 || digest_valid !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || ld_msg !== 1'b0 || ld_cnt !== 1'b0 || blk_cnt !== 32'd0) begin
            n_fail++; $display("FAIL arst_midblk got start=%b dv=%b rv=%b err=%b ldm=%b ldc=%b blk=%0d exp all 0", start, digest_valid, rvalid, err, ld_msg, ld_cnt, blk_cnt); end
        @(negedge clk); rst = 1'b0; exp_blk = 0;
        step(1'b1, DW'($urandom), 1'b0);
        n_tests++; if (o_ldc !== 1'b1 || o_ldm !== 1'b0) begin n_fail++; $display("FAIL arst_midblk_len got ldc=%b ldm=%b exp 1 0", o_ldc, o_ldm); end
        do_reset();
        set_digest(1'b1);
        run_block(1'b1, 4);
        for (int k = 0; k < 7; k++) step(1'b0, '0, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (rvalid !== 1'b0 || rdata !== '0 || digest_valid !== 1'b0 || blk_cnt !== 32'd0) begin
            n_fail++; $display("FAIL arst_midread got rv=%b rdata=%h dv=%b blk=%0d exp 0 0 0 0", rvalid, rdata, digest_valid, blk_cnt); end
        @(negedge clk); rst = 1'b0; exp_blk = 0;
        step(1'b1, DW'($urandom), 1'b0);
        n_tests++; if (o_ldc !== 1'b1 || o_err !== 1'b0) begin n_fail++; $display("FAIL arst_midread_len got ldc=%b err=%b exp 1 0", o_ldc, o_err); end
    endtask

    task automatic test_wide();
        logic [DW2-1:0] d;
        int bad;
        do_reset();
        for (int k = 0; k < NR2; k++) words2[k] = DW2'($urandom);
        digest2 = '0;
        for (int k = 0; k < NR2; k++) digest2 = {digest2[GW2-DW2-1:0], words2[k]};
        bad = 0;
        for (int i = 0; i < LW2; i++) begin
            d = DW2'($urandom); step2(1'b1, d, 1'b0);
            if (p_ldc !== 1'b1 || p_ldm !== 1'b0 || p_wrdy !== 1'b1 || p_cd !== d) bad++;
        end
        for (int i = 0; i < BW2; i++) begin
            d = DW2'($urandom); step2(1'b1, d, 1'b0);
            if (p_ldc !== 1'b0 || p_ldm !== 1'b1 || p_start !== 1'b0 || p_cd !== d) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wide_load got %0d bad cycles exp 0", bad); end
        step2(1'b0, '0, 1'b0);
        n_tests++; if (p_start !== 1'b1) begin n_fail++; $display("FAIL wide_start got %b exp 1", p_start); end
        busy2 = 1'b1;
        bad = 0;
        repeat (3) begin step2(1'b0, '0, 1'b0); if (p_start !== 1'b0 || p_dv !== 1'b0) bad++; end
        busy2 = 1'b0;
        step2(1'b0, '0, 1'b0);
        n_tests++; if (bad !== 0 || p_dv !== 1'b1) begin n_fail++; $display("FAIL wide_busy got bad=%0d dv=%b exp 0 1", bad, p_dv); end
        n_tests++; if (blk_cnt2 !== (BLK_EN ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL wide_blk_cnt got %0d exp %0d", blk_cnt2, BLK_EN ? 1 : 0); end
        for (int k = 0; k < NR2; k++) begin
            if ($urandom_range(0, 1) == 0) step2(1'b0, '0, 1'b0);
            step2(1'b0, '0, 1'b1);
            n_tests++;
            if (p_rv !== 1'b1 || p_rd !== words2[k] || p_err !== 1'b0) begin
                n_fail++; $display("FAIL wide_read %0d got rv=%b rdata=%h err=%b exp 1 %h 0", k, p_rv, p_rd, p_err, words2[k]);
            end
        end
        n_tests++; if (p_dv !== 1'b0) begin n_fail++; $display("FAIL wide_dv_clear got %b exp 0", p_dv); end
    endtask

    initial begin
        test_reset();
        test_block();
        test_read(1'b1);
        test_read(1'b0);
        test_two_block();
        test_illegal();
        test_async_reset();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
